// File: rtl/mem_access_pkg.sv
// Shared types and constants for the data-memory load/store controller.
package mem_access_pkg;

    localparam int unsigned WORD_BYTES = 4;
    localparam int unsigned WORD_SHIFT = 2;

    localparam int unsigned ADDR_W_DEF = 7;
    localparam int unsigned DATA_W_DEF = 32;
    localparam int unsigned LEN_W_DEF  = 2;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WR       = 2'd1,
        RD_ISSUE = 2'd2,
        RD_HOLD  = 2'd3
    } state_e;

endpackage

// File: rtl/mem_access_ctrl_burst_addr_counter.sv
// Burst address generator: holds the word-aligned base, burst length and beat
// index, and presents the current and next word address with wrap.
//   clk, rst_n      clock, async active-low reset
//   load            capture load_addr/load_len and restart at beat 0
//   load_addr       byte start address (low bits dropped)
//   load_len        words minus one
//   advance         step to the next beat
//   cur_addr_c      base + WORD_BYTES*beat, modulo 2^ADDR_W
//   next_addr_c     cur_addr_c + WORD_BYTES, modulo 2^ADDR_W
//   last_c          current beat is the final one of the burst
module burst_addr_counter
    import mem_access_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned LEN_W  = LEN_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [LEN_W-1:0]  load_len,
    input  logic              advance,
    output logic [ADDR_W-1:0] cur_addr_c,
    output logic [ADDR_W-1:0] next_addr_c,
    output logic              last_c
);

    logic [ADDR_W-1:0] base_q, base_d;
    logic [LEN_W-1:0]  len_q,  len_d;
    logic [LEN_W-1:0]  beat_q, beat_d;

    // Load wins over advance; beat never steps past len because the FSM
    // leaves the burst on the last beat.
    always_comb begin
        base_d = base_q;
        len_d  = len_q;
        beat_d = beat_q;
        if (load) begin
            base_d = load_addr & ~ADDR_W'(WORD_BYTES - 1);
            len_d  = load_len;
            beat_d = '0;
        end else if (advance) begin
            beat_d = beat_q + LEN_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            base_q <= '0;
            len_q  <= '0;
            beat_q <= '0;
        end else begin
            base_q <= base_d;
            len_q  <= len_d;
            beat_q <= beat_d;
        end
    end

    // Adds truncate to ADDR_W, giving the wrap from the top word to 0.
    assign cur_addr_c  = base_q + (ADDR_W'(beat_q) << WORD_SHIFT);
    assign next_addr_c = cur_addr_c + ADDR_W'(WORD_BYTES);
    assign last_c      = (beat_q == len_q);

endmodule

// File: rtl/mem_access_ctrl.sv
// Initiator-side load/store controller for a single-port data memory
// (posedge write, negedge read). Bursts of 1..4 words over valid/ready.
//   clk, rst_n                      clock, async active-low reset
//   req_valid/ready/write/addr/len  burst request handshake
//   wd_valid/ready/data             store beats in
//   rd_valid/ready/data             load beats out (registered)
//   done                            one-cycle pulse as a burst retires
//   mem_write/read/address/wdata    memory controls, decoded from state
//   mem_rdata                       memory read data (valid after negedge)
module mem_access_ctrl
    import mem_access_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned LEN_W  = LEN_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [LEN_W-1:0]  req_len,
    input  logic              wd_valid,
    output logic              wd_ready,
    input  logic [DATA_W-1:0] wd_data,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic [DATA_W-1:0] rd_data,
    output logic              done,
    output logic              mem_write,
    output logic              mem_read,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    state_e            state_q, state_d;
    logic              rd_valid_q, rd_valid_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;
    logic              done_q, done_d;

    logic              ctr_load;
    logic              ctr_adv;
    logic [ADDR_W-1:0] cur_addr_c;
    logic [ADDR_W-1:0] next_addr_c;
    logic              last_c;
    logic              hold_adv_c;

    burst_addr_counter #(
        .ADDR_W (ADDR_W),
        .LEN_W  (LEN_W)
    ) u_addr_ctr (
        .clk         (clk),
        .rst_n       (rst_n),
        .load        (ctr_load),
        .load_addr   (req_addr),
        .load_len    (req_len),
        .advance     (ctr_adv),
        .cur_addr_c  (cur_addr_c),
        .next_addr_c (next_addr_c),
        .last_c      (last_c)
    );

    // Consumer takes a non-final read beat: fetch the following word now.
    assign hold_adv_c = (state_q == RD_HOLD) && rd_ready && !last_c;

    // State and read-capture registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
            done_q     <= done_d;
        end
    end

    // Next state, read capture and counter control.
    always_comb begin
        state_d    = state_q;
        rd_valid_d = rd_valid_q;
        rd_data_d  = rd_data_q;
        done_d     = 1'b0;
        ctr_load   = 1'b0;
        ctr_adv    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (req_valid) begin
                    ctr_load = 1'b1;
                    state_d  = req_write ? WR : RD_ISSUE;
                end
            end
            WR: begin
                if (wd_valid) begin
                    if (last_c) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        ctr_adv = 1'b1;
                    end
                end
            end
            RD_ISSUE: begin
                rd_data_d  = mem_rdata;
                rd_valid_d = 1'b1;
                state_d    = RD_HOLD;
            end
            RD_HOLD: begin
                if (rd_ready) begin
                    if (last_c) begin
                        rd_valid_d = 1'b0;
                        done_d     = 1'b1;
                        state_d    = IDLE;
                    end else begin
                        rd_data_d = mem_rdata;
                        ctr_adv   = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Memory and handshake controls decode straight from state so reset
    // drops them immediately.
    always_comb begin
        req_ready   = (state_q == IDLE);
        wd_ready    = (state_q == WR);
        mem_write   = (state_q == WR) && wd_valid;
        mem_read    = (state_q == RD_ISSUE) || hold_adv_c;
        mem_address = hold_adv_c ? next_addr_c : cur_addr_c;
        mem_wdata   = wd_data;
    end

    assign rd_valid = rd_valid_q;
    assign rd_data  = rd_data_q;
    assign done     = done_q;

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
- Initiator-side load/store controller for the single-port data memory (posedge write, negedge read, word index = address[6:2]).
- Accepts burst requests of 1–4 words from the datapath over valid/ready.
- Streams write beats into the memory and read beats back out over valid/ready.
- Drives the memory's write-enable, read-enable, address and write-data, and captures its read data.

Parameters:
- ADDR_W, 7, memory byte-address width.
- DATA_W, 32, word width.
- LEN_W, 2, burst length field width; burst = req_len+1 words (1..4).

Ports:
- clk  in  1  single clock; all state changes on posedge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  request offered.
- req_ready  out  1  controller idle, request accepted when req_valid && req_ready.
- req_write  in  1  1 = store burst, 0 = load burst.
- req_addr  in  ADDR_W  byte start address; bits [1:0] ignored (forced 0).
- req_len  in  LEN_W  words minus one.
- wd_valid  in  1  write beat offered.
- wd_ready  out  1  write beat accepted this cycle.
- wd_data  in  DATA_W  write beat data.
- rd_valid  out  1  read beat held on rd_data.
- rd_ready  in  1  consumer takes read beat.
- rd_data  out  DATA_W  read beat data.
- done  out  1  one-cycle pulse after the last beat of a burst completes.
- mem_write  out  1  memory write enable.
- mem_read  out  1  memory read enable.
- mem_address  out  ADDR_W  memory byte address, word aligned.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data, updated on negedge when mem_read is high.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, beat=0, rd_valid=0, rd_data=0, done=0, latched addr/len/write=0.
  - mem_write, mem_read, wd_ready go 0 immediately, since they decode from state.
  - req_ready=1 once released.
  - Reset mid-burst abandons the burst; no done pulse; memory words already written stay written.
- States: IDLE, WR, RD_ISSUE, RD_HOLD.
- IDLE:
  - req_ready=1.
  - On accept: latch addr (bits[1:0]=0), len, write; beat=0.
  - Next state is WR if write, else RD_ISSUE.
- Address: mem_address = base + 4*beat, modulo 2^ADDR_W (byte 124 + 4 wraps to 0).
- WR:
  - wd_ready=1; mem_write=wd_valid; mem_wdata=wd_data.
  - The memory writes at the posedge ending the cycle.
  - Each accepted beat increments beat. When the accepted beat is beat==len, go to IDLE and set done=1 for the next cycle.
  - wd_valid=0 stalls the burst with no memory activity.
- RD_ISSUE:
  - mem_read=1 for one cycle.
  - The memory updates mem_rdata at the mid-cycle negedge; the controller captures it on the closing posedge: rd_data<=mem_rdata, rd_valid<=1, next RD_HOLD.
  - Latency from request accept to first rd_valid: 2 cycles.
- RD_HOLD:
  - rd_valid=1; rd_data stable while rd_ready=0.
  - If rd_ready && beat<len: mem_read=1 in the same cycle at address base+4*(beat+1), capture on the posedge, beat++, stay RD_HOLD. Sustained 1 beat/cycle.
  - If rd_ready && beat==len: rd_valid<=0, done<=1, go to IDLE.
- mem_read and mem_write are never high together. Neither is high in IDLE.
- done is high exactly one cycle, coincident with req_ready returning to 1. A new request may be accepted in that same cycle.
- wd_valid outside WR is ignored; rd_ready while rd_valid=0 is ignored.

Decomposition:
- Shared package mem_access_pkg:
  - state enum (IDLE, WR, RD_ISSUE, RD_HOLD).
  - WORD_BYTES=4.
  - defaults for ADDR_W, DATA_W, LEN_W.
- One natural sub-module, burst_addr_counter:
  - holds beat and base.
  - outputs the current and next word address with wrap, plus a last flag.
- The FSM and read-capture register stay in the top.

Test Plan:
- Memory model preloaded Mem[0..2]=5,6,7. Load addr=0, len=2, rd_ready=1 → rd_data 5,6,7 on 3 consecutive cycles, first 2 cycles after accept; done one cycle after last beat.
- Store addr=0x10, len=3, data 0xA,0xB,0xC,0xD with wd_valid gapped (1,0,1,1,1) → mem_write only on valid cycles, addresses 0x10,0x14,0x18,0x1C; follow-up load reads back 0xA..0xD.
- Load addr=0x7C, len=1 → addresses 0x7C then 0x00 (wrap); rd_data = Mem[31], then Mem[0]=5.
- Load len=3 with rd_ready low for 3 cycles on beat 1 → rd_data holds beat-1 value, mem_read low during stall, no beat lost or duplicated.
- Store addr=0x03 → address forced to 0x00; Mem[0] overwritten, Mem[1]=6 untouched.
- Assert rst_n=0 in the middle of a 4-word store after 2 beats → mem_write drops the same cycle, no done; after release, req_ready=1 and Mem holds exactly the 2 written words.
